// File: rtl/mem_arbiter_if.sv
// Fetch/data requester ports and the shared memory command/response bundle.
// slave = arbiter side, master = requesters plus memory (environment side).
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        err;
    logic        busy;
    logic [1:0]  grant;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata,
               err, busy, grant
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done, mem_en, mem_we, mem_addr, mem_wdata,
               err, busy, grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of a fetch and a data port onto one memory; req->done min 2 cycles.
// Requesters hold req until done; the loser waits in IDLE; ACCESS times out after MAX_WAIT cycles.
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        cur_data;
    logic        last_data;
    logic        err_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        pick_data;
    logic        timeout;

    always_comb begin
        // Data wins if it is alone, or on contention when fetch was served last.
        pick_data = bus.d_req && (!bus.if_req || !last_data);
        timeout   = (wait_cnt == WAIT_LAST);
        state_nxt = state;
        case (state)
            IDLE:    if (bus.if_req || bus.d_req)     state_nxt = ACCESS;
            ACCESS:  if (bus.mem_ready || timeout)    state_nxt = RESP;
            RESP:                                     state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            cur_data   <= 1'b0;
            last_data  <= 1'b1;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (state_nxt == ACCESS) begin
                        cur_data  <= pick_data;
                        last_data <= pick_data;
                        wait_cnt  <= 4'd0;
                        addr_q    <= pick_data ? bus.d_addr : bus.if_addr;
                        we_q      <= pick_data && bus.d_we;
                        wdata_q   <= pick_data ? bus.d_wdata : 32'd0;
                    end
                end
                ACCESS: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    // Leaving ACCESS without mem_ready can only mean the wait expired.
                    if (state_nxt == RESP)
                        err_q <= !bus.mem_ready;
                    if (bus.mem_ready && !we_q) begin
                        if (cur_data) d_rdata_q  <= bus.mem_rdata;
                        else          if_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != IDLE);
    assign bus.grant     = (state == IDLE) ? 2'b00 : (cur_data ? 2'b10 : 2'b01);
    assign bus.if_done   = (state == RESP) && !cur_data;
    assign bus.d_done    = (state == RESP) &&  cur_data;
    assign bus.err       = (state == RESP) &&  err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, contention, write, timeout, mid-access reset.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_WAIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        n_total++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en got %b want 0", bus.mem_en); else n_pass++;
        n_total++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 65'd0) $display("FAIL rst_mem_cmd got we=%b addr=%h wdata=%h want 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); else n_pass++;
        n_total++; if ({bus.if_done, bus.d_done, bus.err, bus.busy} !== 4'b0000) $display("FAIL rst_flags got %b want 0000", {bus.if_done, bus.d_done, bus.err, bus.busy}); else n_pass++;
        n_total++; if (bus.grant !== 2'b00) $display("FAIL rst_grant got %b want 00", bus.grant); else n_pass++;
        n_total++; if ({bus.if_rdata, bus.d_rdata} !== 64'd0) $display("FAIL rst_rdata got %h/%h want 0", bus.if_rdata, bus.d_rdata); else n_pass++;
        reset = 1'b1;
        step();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rst_release_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_single_fetch;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0010;
        step();
        n_total++; if (bus.mem_en !== 1'b1) $display("FAIL fetch_mem_en got %b want 1", bus.mem_en); else n_pass++;
        n_total++; if (bus.grant !== 2'b01) $display("FAIL fetch_grant got %b want 01", bus.grant); else n_pass++;
        n_total++; if ({bus.mem_we, bus.mem_addr} !== {1'b0, 32'h0000_0010}) $display("FAIL fetch_cmd got we=%b addr=%h want we=0 addr=00000010", bus.mem_we, bus.mem_addr); else n_pass++;
        step();
        n_total++; if ({bus.mem_en, bus.if_done} !== 2'b10) $display("FAIL fetch_wait got en/done=%b want 10", {bus.mem_en, bus.if_done}); else n_pass++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        step();
        n_total++; if ({bus.if_done, bus.d_done, bus.err} !== 3'b100) $display("FAIL fetch_done got if/d/err=%b want 100", {bus.if_done, bus.d_done, bus.err}); else n_pass++;
        n_total++; if (bus.if_rdata !== 32'h1234_5678) $display("FAIL fetch_rdata got %h want 12345678", bus.if_rdata); else n_pass++;
        n_total++; if ({bus.mem_en, bus.grant} !== 3'b001) $display("FAIL fetch_resp_grant got en=%b grant=%b want en=0 grant=01", bus.mem_en, bus.grant); else n_pass++;
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        n_total++; if ({bus.if_done, bus.busy, bus.grant} !== 4'b0000) $display("FAIL fetch_idle got done/busy/grant=%b want 0000", {bus.if_done, bus.busy, bus.grant}); else n_pass++;
        n_total++; if (bus.if_rdata !== 32'h1234_5678) $display("FAIL fetch_rdata_hold got %h want 12345678", bus.if_rdata); else n_pass++;
    endtask

    task automatic test_contention;
        do_reset();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0100;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_0200;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hAAAA_0001;
        step();
        n_total++; if ({bus.mem_en, bus.grant, bus.mem_addr} !== {1'b1, 2'b01, 32'h100}) $display("FAIL cont_first got en=%b grant=%b addr=%h want 1/01/00000100", bus.mem_en, bus.grant, bus.mem_addr); else n_pass++;
        step();
        n_total++; if ({bus.if_done, bus.d_done} !== 2'b10 || bus.if_rdata !== 32'hAAAA_0001) $display("FAIL cont_first_done got done=%b rdata=%h want 10/aaaa0001", {bus.if_done, bus.d_done}, bus.if_rdata); else n_pass++;
        bus.mem_rdata = 32'hBBBB_0002;
        step();
        n_total++; if ({bus.mem_en, bus.grant} !== 3'b000 || bus.if_rdata !== 32'hAAAA_0001) $display("FAIL cont_idle got en=%b grant=%b rdata=%h want 0/00/aaaa0001", bus.mem_en, bus.grant, bus.if_rdata); else n_pass++;
        step();
        n_total++; if ({bus.mem_en, bus.grant, bus.mem_addr} !== {1'b1, 2'b10, 32'h200}) $display("FAIL cont_second got en=%b grant=%b addr=%h want 1/10/00000200", bus.mem_en, bus.grant, bus.mem_addr); else n_pass++;
        step();
        n_total++; if ({bus.if_done, bus.d_done} !== 2'b01 || bus.d_rdata !== 32'hBBBB_0002) $display("FAIL cont_second_done got done=%b rdata=%h want 01/bbbb0002", {bus.if_done, bus.d_done}, bus.d_rdata); else n_pass++;
        step();
        step();
        n_total++; if (bus.grant !== 2'b01) $display("FAIL cont_third_grant got %b want 01", bus.grant); else n_pass++;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();
        n_total++; if (bus.if_done !== 1'b1) $display("FAIL cont_third_done got %b want 1", bus.if_done); else n_pass++;
        bus.mem_ready = 1'b0;
        step();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL cont_end_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_data_write;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h0000_0040;
        bus.d_wdata   = 32'hCAFE_F00D;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            n_total++; if ({bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_addr} !== {1'b1, 1'b1, 32'hCAFE_F00D, 32'h40}) $display("FAIL wr_cmd_%0d got en=%b we=%b wdata=%h addr=%h want 1/1/cafef00d/00000040", i, bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_addr); else n_pass++;
            step();
        end
        n_total++; if (bus.grant !== 2'b10) $display("FAIL wr_grant got %b want 10", bus.grant); else n_pass++;
        bus.mem_ready = 1'b1;
        step();
        n_total++; if ({bus.d_done, bus.if_done, bus.err} !== 3'b100) $display("FAIL wr_done got d/if/err=%b want 100", {bus.d_done, bus.if_done, bus.err}); else n_pass++;
        n_total++; if (bus.d_rdata !== 32'hBBBB_0002) $display("FAIL wr_rdata_kept got %h want bbbb0002", bus.d_rdata); else n_pass++;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout;
        int cyc;
        cyc = 0;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h0000_0080;
        bus.mem_rdata = 32'h5555_5555;
        bus.mem_ready = 1'b0;
        step();
        while (bus.mem_en === 1'b1 && cyc < 40) begin
            cyc++;
            step();
        end
        n_total++; if (cyc != 15) $display("FAIL to_en_cycles got %0d want 15", cyc); else n_pass++;
        n_total++; if ({bus.d_done, bus.err} !== 2'b11) $display("FAIL to_done_err got done/err=%b want 11", {bus.d_done, bus.err}); else n_pass++;
        n_total++; if (bus.d_rdata !== 32'hBBBB_0002) $display("FAIL to_rdata_kept got %h want bbbb0002", bus.d_rdata); else n_pass++;
        bus.d_req = 1'b0;
        step();
        n_total++; if ({bus.busy, bus.err, bus.d_done} !== 3'b000) $display("FAIL to_idle got busy/err/done=%b want 000", {bus.busy, bus.err, bus.d_done}); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0020;
        step();
        n_total++; if (bus.mem_en !== 1'b1) $display("FAIL rm_pre_access got %b want 1", bus.mem_en); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_total++; if ({bus.mem_en, bus.busy, bus.grant, bus.if_done} !== 5'b00000) $display("FAIL rm_async_ctrl got en/busy/grant/done=%b want 00000", {bus.mem_en, bus.busy, bus.grant, bus.if_done}); else n_pass++;
        n_total++; if ({bus.mem_addr, bus.d_rdata} !== 64'd0) $display("FAIL rm_async_regs got addr=%h d_rdata=%h want 0", bus.mem_addr, bus.d_rdata); else n_pass++;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h0000_0300;
        step();
        n_total++; if ({bus.if_done, bus.d_done} !== 2'b00) $display("FAIL rm_no_done got %b want 00", {bus.if_done, bus.d_done}); else n_pass++;
        reset = 1'b1;
        step();
        n_total++; if ({bus.grant, bus.mem_addr} !== {2'b01, 32'h20}) $display("FAIL rm_after_grant got grant=%b addr=%h want 01/00000020", bus.grant, bus.mem_addr); else n_pass++;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_0077;
        step();
        n_total++; if ({bus.if_done, bus.d_done} !== 2'b10 || bus.if_rdata !== 32'h77) $display("FAIL rm_after_done got done=%b rdata=%h want 10/00000077", {bus.if_done, bus.d_done}, bus.if_rdata); else n_pass++;
        bus.if_req    = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rm_end_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_data_write();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, max cycles a granted access waits for mem_ready before timeout (range 1-15).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports if_req in 1 (fetch request), if_addr in 32 (fetch address).
REQ-005 SHALL have ports if_rdata out 32 (fetch read data) and if_done out 1 (fetch completion pulse).
REQ-006 SHALL have ports d_req in 1, d_we in 1 (1=write), d_addr in 32, d_wdata in 32 (data-port request).
REQ-007 SHALL have ports d_rdata out 32 (data read data) and d_done out 1 (data completion pulse).
REQ-008 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32 (shared memory command).
REQ-009 SHALL have ports mem_rdata in 32 and mem_ready in 1 (memory response).
REQ-010 SHALL have ports err out 1 (timeout flag, valid with done), busy out 1 (state != IDLE), grant out 2 (01=fetch, 10=data, 00=none).

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on any req, ACCESS->RESP on mem_ready or timeout, RESP->IDLE unconditionally.
REQ-012 SHALL sample requests only in IDLE; requester holds req, address and write data stable until its done pulse.
REQ-013 SHALL arbitrate round-robin: one requester -> grant it; both -> grant the port not granted last; last-grant register resets to "data" so fetch wins first contention.
REQ-014 SHALL register the granted port's address, we (0 for fetch), wdata into mem_addr/mem_we/mem_wdata on the IDLE->ACCESS edge and hold them constant throughout ACCESS.
REQ-015 SHALL assert mem_en only and continuously in ACCESS; grant reflects the granted port in ACCESS and RESP, 00 in IDLE.
REQ-016 SHALL, when mem_ready=1 in ACCESS, capture mem_rdata into the granted port's rdata register (reads only; writes leave rdata unchanged) and enter RESP.
REQ-017 SHALL pulse exactly one of if_done/d_done high for exactly the single RESP cycle; rdata valid from that cycle and held until overwritten by a later read on the same port.
REQ-018 SHALL count ACCESS cycles in a 4-bit counter cleared on entry; if the count reaches MAX_WAIT with mem_ready=0, enter RESP with err=1, rdata unchanged.
REQ-019 SHALL drive err=0 on non-timeout completions; err is meaningful only in RESP.
REQ-020 Minimum latency: req at cycle N (IDLE), mem_en at N+1, mem_ready at N+1 -> done at N+2; next grant earliest N+3 mem_en at N+4.
REQ-021 SHALL ignore mem_ready outside ACCESS.
REQ-022 SHALL ignore req deassertion mid-transaction; access completes and done still pulses.
REQ-023 SHALL never issue two outstanding accesses; the losing requester waits, with no loss of its request.

Reset
REQ-024 SHALL on reset=0 immediately (asynchronously) enter IDLE and drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, err=0, busy=0, grant=00, if_rdata=0, d_rdata=0, counter=0, last-grant=data.
REQ-025 SHALL, on reset mid-ACCESS, abort without any done pulse; first access after release follows REQ-013 from reset state.

Verification
REQ-026 Single fetch: if_req=1, if_addr=0x0000_0010, mem_ready one cycle after mem_en with mem_rdata=0x1234_5678 -> if_done pulse 1 cycle, if_rdata=0x1234_5678, err=0, grant=01 during access.
REQ-027 Contention: if_req and d_req asserted same cycle after reset, held -> fetch served first, data second, then on re-contention fetch again (alternating).
REQ-028 Data write: d_we=1, d_addr=0x40, d_wdata=0xCAFE_F00D, 3-cycle ready delay -> mem_we=1, mem_wdata=0xCAFE_F00D stable 3 cycles, d_done pulse, d_rdata unchanged.
REQ-029 Timeout: d_req read, mem_ready stuck 0, MAX_WAIT=15 -> mem_en high exactly 15 cycles, d_done with err=1, d_rdata unchanged, FSM back to IDLE.
REQ-030 Reset mid-access: reset low during ACCESS -> all outputs zero same cycle, no done pulse; post-release fetch request served normally.
